// File: rtl/greycode_pkg.sv
`default_nettype none
// ============================================================================
// Module      : greycode_pkg
// Description : Shared definitions for the grey-code stream blocks.
//               - GREY_WIDTH      : default sample / grey word width
//               - GREY_MAX_WIDTH  : widest word the helper functions handle
//               - skid_state_e    : occupancy states of the skid buffer
//               - bin2grey        : binary -> grey (width generic via zero-ext)
//               - grey2bin        : grey -> binary (width generic via zero-ext)
//               - popcount        : number of set bits in a word
// Revision    : 1.0 - initial release
// ============================================================================
package greycode_pkg;

    localparam int GREY_WIDTH     = 8;
    localparam int GREY_MAX_WIDTH = 64;

    typedef logic [GREY_MAX_WIDTH-1:0] grey_word_t;

    typedef enum logic [1:0] {
        SKID_EMPTY = 2'd0,
        SKID_ONE   = 2'd1,
        SKID_FULL  = 2'd2
    } skid_state_e;

    // Callers zero-extend narrower words into grey_word_t. Zero upper bits
    // stay zero through both conversions, so the low WIDTH bits of the result
    // are exactly the WIDTH-bit conversion.
    function automatic grey_word_t bin2grey(input grey_word_t b);
        return b ^ (b >> 1);
    endfunction

    // Each binary bit is the XOR of all grey bits at and above it.
    function automatic grey_word_t grey2bin(input grey_word_t g);
        grey_word_t b;
        b = '0;
        b[GREY_MAX_WIDTH-1] = g[GREY_MAX_WIDTH-1];
        for (int i = GREY_MAX_WIDTH - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    function automatic logic [6:0] popcount(input grey_word_t v);
        logic [6:0] cnt;
        cnt = '0;
        for (int i = 0; i < GREY_MAX_WIDTH; i++) begin
            cnt = cnt + 7'(v[i]);
        end
        return cnt;
    endfunction

endpackage
`default_nettype wire

// File: rtl/greycode_encoder_stream_grey_skid_buffer.sv
`default_nettype none
// ============================================================================
// Module      : grey_skid_buffer
// Description : Two-entry valid/ready skid buffer. in_ready and out_valid are
//               both flops, so neither handshake has a combinational path
//               through this block. Words leave in acceptance order.
// Ports       : clk, rst_n (async active-low)
//               in_valid / in_ready / in_data    - upstream handshake
//               out_valid / out_ready / out_data - downstream handshake
// Revision    : 1.0 - initial release
// ============================================================================
module grey_skid_buffer
    import greycode_pkg::*;
#(
    parameter int WIDTH = GREY_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data
);

    skid_state_e      state_q, state_d;
    logic [WIDTH-1:0] head_q,  head_d;
    logic [WIDTH-1:0] skid_q,  skid_d;
    logic             in_ready_q,  in_ready_d;
    logic             out_valid_q, out_valid_d;

    logic w_accept;
    logic w_drain;

    assign w_accept = in_valid && in_ready_q;
    assign w_drain  = out_valid_q && out_ready;

    always_comb begin
        state_d = state_q;
        head_d  = head_q;
        skid_d  = skid_q;

        case (state_q)
            SKID_EMPTY: begin
                if (w_accept) begin
                    head_d  = in_data;
                    state_d = SKID_ONE;
                end
            end
            SKID_ONE: begin
                if (w_accept && w_drain) begin
                    // Head leaves as the new word arrives: replace in place.
                    head_d = in_data;
                end else if (w_accept) begin
                    skid_d  = in_data;
                    state_d = SKID_FULL;
                end else if (w_drain) begin
                    state_d = SKID_EMPTY;
                end
            end
            SKID_FULL: begin
                // in_ready is low here, so only a drain can occur.
                if (w_drain) begin
                    head_d  = skid_q;
                    state_d = SKID_ONE;
                end
            end
            default: begin
                state_d = SKID_EMPTY;
            end
        endcase

        // Handshake flags are registered copies of the next-state decode.
        in_ready_d  = (state_d != SKID_FULL);
        out_valid_d = (state_d != SKID_EMPTY);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= SKID_EMPTY;
            head_q      <= '0;
            skid_q      <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            head_q      <= head_d;
            skid_q      <= skid_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_data  = head_q;

endmodule
`default_nettype wire

// File: rtl/greycode_encoder_stream.sv
`default_nettype none
// ============================================================================
// Module      : greycode_encoder_stream
// Description : Streaming binary-to-grey encoder. Samples are encoded as they
//               are accepted and the grey words are held in a two-entry skid
//               buffer, giving one cycle of latency and full throughput.
// Macro       : GREYCODE_ENC_STATS_EN - adds stats_clr, sample_cnt, adj_cnt
//               and the CNT_WIDTH parameter. Datapath is identical either way.
// Ports       : clk, rst_n (async active-low)
//               in_valid / in_ready / in_data     - binary sample input
//               out_valid / out_ready / out_grey  - grey word output
//               stats_clr, sample_cnt, adj_cnt    - optional statistics
// Revision    : 1.0 - initial release
// ============================================================================
module greycode_encoder_stream
    import greycode_pkg::*;
#(
    parameter int WIDTH = GREY_WIDTH
`ifdef GREYCODE_ENC_STATS_EN
    ,
    parameter int CNT_WIDTH = 16
`endif
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     in_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [WIDTH-1:0]     out_grey
`ifdef GREYCODE_ENC_STATS_EN
    ,
    input  logic                 stats_clr,
    output logic [CNT_WIDTH-1:0] sample_cnt,
    output logic [CNT_WIDTH-1:0] adj_cnt
`endif
);

    logic [WIDTH-1:0] w_in_grey;

    // The buffer stores grey words, so encoding sits on the input side.
    assign w_in_grey = WIDTH'(bin2grey(grey_word_t'(in_data)));

    grey_skid_buffer #(
        .WIDTH (WIDTH)
    ) u_skid (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (w_in_grey),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_grey)
    );

`ifdef GREYCODE_ENC_STATS_EN
    logic [CNT_WIDTH-1:0] sample_cnt_q, sample_cnt_d;
    logic [CNT_WIDTH-1:0] adj_cnt_q,    adj_cnt_d;
    logic [WIDTH-1:0]     prev_grey_q,  prev_grey_d;
    logic                 prev_valid_q, prev_valid_d;

    logic w_out_xfer;
    logic w_adjacent;

    assign w_out_xfer = out_valid && out_ready;
    assign w_adjacent = prev_valid_q &&
                        (popcount(grey_word_t'(out_grey ^ prev_grey_q)) == 7'd1);

    always_comb begin
        sample_cnt_d = sample_cnt_q;
        adj_cnt_d    = adj_cnt_q;
        prev_grey_d  = prev_grey_q;
        prev_valid_d = prev_valid_q;

        if (w_out_xfer) begin
            // Counters stick at all-ones rather than wrapping.
            if (sample_cnt_q != '1) begin
                sample_cnt_d = sample_cnt_q + CNT_WIDTH'(1);
            end
            if (w_adjacent && (adj_cnt_q != '1)) begin
                adj_cnt_d = adj_cnt_q + CNT_WIDTH'(1);
            end
            prev_grey_d  = out_grey;
            prev_valid_d = 1'b1;
        end

        // Clear overrides any increment on the same edge.
        if (stats_clr) begin
            sample_cnt_d = '0;
            adj_cnt_d    = '0;
            prev_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sample_cnt_q <= '0;
            adj_cnt_q    <= '0;
            prev_grey_q  <= '0;
            prev_valid_q <= 1'b0;
        end else begin
            sample_cnt_q <= sample_cnt_d;
            adj_cnt_q    <= adj_cnt_d;
            prev_grey_q  <= prev_grey_d;
            prev_valid_q <= prev_valid_d;
        end
    end

    assign sample_cnt = sample_cnt_q;
    assign adj_cnt    = adj_cnt_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_greycode_encoder_stream.sv
`default_nettype none
// ============================================================================
// Module      : tb_greycode_encoder_stream
// Description : Self-checking bench for greycode_encoder_stream. Stimulus
//               pushes accepted samples into a scoreboard queue; a monitor on
//               the falling edge pops and compares every emitted word, checks
//               handshake flags against queue occupancy, and (with
//               GREYCODE_ENC_STATS_EN) tracks the statistics counters.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_greycode_encoder_stream;

    localparam int W = 8;

    logic         clk       = 1'b0;
    logic         rst_n     = 1'b0;
    logic         in_valid  = 1'b0;
    logic [W-1:0] in_data   = '0;
    logic         out_ready = 1'b0;
    logic         in_ready;
    logic         out_valid;
    logic [W-1:0] out_grey;
`ifdef GREYCODE_ENC_STATS_EN
    logic         stats_clr = 1'b0;
    logic [15:0]  sample_cnt;
    logic [15:0]  adj_cnt;
    int           exp_sample;
    int           exp_adj;
    bit           exp_prev_v;
    logic [W-1:0] exp_prev;
`endif

    greycode_encoder_stream #(
        .WIDTH     (W)
`ifdef GREYCODE_ENC_STATS_EN
        ,
        .CNT_WIDTH (16)
`endif
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_grey   (out_grey)
`ifdef GREYCODE_ENC_STATS_EN
        ,
        .stats_clr  (stats_clr),
        .sample_cnt (sample_cnt),
        .adj_cnt    (adj_cnt)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] b;
        logic [W-1:0] g;
    } item_t;

    item_t        sb[$];
    int           checks = 0;
    int           errors = 0;
    int           pushed = 0;
    int           popped = 0;
    bit           stalled = 0;
    logic [W-1:0] held;

    // Reference rule: each grey bit flags a change between neighbouring
    // binary bits; the top bit is copied.
    function automatic logic [W-1:0] ref_grey(input logic [W-1:0] b);
        logic [W-1:0] g;
        g[W-1] = b[W-1];
        for (int i = 0; i < W - 1; i++) g[i] = (b[i] != b[i+1]);
        return g;
    endfunction

    function automatic logic [W-1:0] ref_decode(input logic [W-1:0] g);
        logic [W-1:0] b;
        b[W-1] = g[W-1];
        for (int i = W - 2; i >= 0; i--) b[i] = b[i+1] ^ g[i];
        return b;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Monitor / scoreboard: inputs are stable at the falling edge, so the
    // transfers that the next rising edge will perform are known here.
    // ------------------------------------------------------------------
    always @(negedge clk) begin
        item_t e;
        if (!rst_n) begin
            sb.delete();
            pushed  = 0;
            popped  = 0;
            stalled = 0;
            chk("rst_in_ready",  in_ready,  1);
            chk("rst_out_valid", out_valid, 0);
            chk("rst_out_grey",  out_grey,  0);
`ifdef GREYCODE_ENC_STATS_EN
            exp_sample = 0;
            exp_adj    = 0;
            exp_prev_v = 0;
            chk("rst_sample_cnt", sample_cnt, 0);
            chk("rst_adj_cnt",    adj_cnt,    0);
`endif
        end else begin
            chk("in_ready_occ",  in_ready,  sb.size() < 2);
            chk("out_valid_occ", out_valid, sb.size() != 0);
            if (stalled) chk("hold_grey", out_grey, held);
`ifdef GREYCODE_ENC_STATS_EN
            chk("sample_cnt", sample_cnt, 64'(exp_sample));
            chk("adj_cnt",    adj_cnt,    64'(exp_adj));
`endif
            if (out_valid && out_ready && sb.size() > 0) begin
                e = sb.pop_front();
                popped++;
                chk("out_grey",    out_grey,             e.g);
                chk("grey_decode", ref_decode(out_grey), e.b);
`ifdef GREYCODE_ENC_STATS_EN
                if (exp_sample < 65535) exp_sample++;
                if (exp_prev_v && $countones(e.g ^ exp_prev) == 1 && exp_adj < 65535)
                    exp_adj++;
                exp_prev   = e.g;
                exp_prev_v = 1;
`endif
            end
            stalled = out_valid && !out_ready;
            held    = out_grey;
            if (in_valid && in_ready) begin
                e.b = in_data;
                e.g = ref_grey(in_data);
                sb.push_back(e);
                pushed++;
            end
`ifdef GREYCODE_ENC_STATS_EN
            if (stats_clr) begin
                exp_sample = 0;
                exp_adj    = 0;
                exp_prev_v = 0;
            end
`endif
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        in_valid = 1'b0;
        rst_n    = 1'b0;
        step();
        rst_n    = 1'b1;
        step();
    endtask

    initial begin
        int acc;
        int cyc;

        // Reset state
        repeat (2) step();
        chk("init_in_ready",  in_ready,  1);
        chk("init_out_valid", out_valid, 0);
        chk("init_out_grey",  out_grey,  0);
        rst_n = 1'b1;
        step();

        // Single sample latency: B4 -> EE for one cycle
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_data   = 8'hB4;
        step();
        in_valid  = 1'b0;
        chk("lat_valid", out_valid, 1);
        chk("lat_grey",  out_grey,  8'hEE);
        step();
        chk("lat_one_cycle", out_valid, 0);

        // Back-to-back stream 0..255
        do_reset();
        out_ready = 1'b1;
        for (int i = 0; i < 256; i++) begin
            in_valid = 1'b1;
            in_data  = W'(i);
            chk("stream_in_ready", in_ready, 1);
            step();
        end
        in_valid = 1'b0;
        repeat (2) step();
        chk("stream_count", popped, 256);
`ifdef GREYCODE_ENC_STATS_EN
        chk("stream_sample_cnt", sample_cnt, 256);
        chk("stream_adj_cnt",    adj_cnt,    255);
`endif

        // Backpressure: two accepted, third waits until release
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = W'($urandom);
        step();
        in_data   = W'($urandom);
        step();
        chk("bp_full_ready", in_ready, 0);
        in_data   = W'($urandom);
        repeat (3) step();
        chk("bp_still_full", in_ready, 0);
        out_ready = 1'b1;
        step();
        chk("bp_release_ready", in_ready, 1);
        step();
        in_valid = 1'b0;
        repeat (3) step();
        chk("bp_drained", out_valid, 0);

        // Asynchronous reset while FULL
        out_ready = 1'b0;
        in_valid  = 1'b1;
        repeat (2) step();
        in_valid  = 1'b0;
        step();
        chk("pre_rst_full", in_ready, 0);
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        chk("async_rst_valid", out_valid, 0);
        chk("async_rst_ready", in_ready,  1);
        chk("async_rst_grey",  out_grey,  0);
`ifdef GREYCODE_ENC_STATS_EN
        chk("async_rst_sample", sample_cnt, 0);
        chk("async_rst_adj",    adj_cnt,    0);
`endif
        step();
        rst_n     = 1'b1;
        out_ready = 1'b1;
        repeat (2) step();
        chk("no_stale_word", out_valid, 0);

`ifdef GREYCODE_ENC_STATS_EN
        // Adjacency counting and clear-wins
        do_reset();
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_data   = 8'h00;
        step();
        in_data   = 8'h03;
        step();
        in_data   = 8'h02;
        step();
        in_valid  = 1'b0;
        repeat (2) step();
        chk("stats_sample3", sample_cnt, 3);
        chk("stats_adj2",    adj_cnt,    2);
        in_valid  = 1'b1;
        in_data   = W'($urandom);
        step();
        in_valid  = 1'b0;
        stats_clr = 1'b1;
        step();
        stats_clr = 1'b0;
        chk("clr_sample", sample_cnt, 0);
        chk("clr_adj",    adj_cnt,    0);
        step();
`endif

        // Randomised traffic, 10k accepted samples
        do_reset();
        acc = 0;
        cyc = 0;
        while (acc < 10000 && cyc < 60000) begin
            in_valid  = 1'($urandom_range(0, 1));
            in_data   = W'($urandom);
            out_ready = 1'($urandom_range(0, 1));
            if (in_valid && in_ready) acc++;
            step();
            cyc++;
        end
        chk("rand_budget", acc >= 10000, 1);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        cyc = 0;
        while (sb.size() != 0 && cyc < 10) begin
            step();
            cyc++;
        end
        step();
        chk("rand_drain_empty", sb.size(), 0);
        chk("rand_no_loss",     popped,    pushed);
        chk("rand_final_idle",  out_valid, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
